// File: rtl/req_chan_pkg.sv
// Shared definitions for the second-generation request-channel master:
// FSM state encoding and the fixed atomic-op code.
package req_chan_pkg;

  typedef enum logic [1:0] {
    REQC_MIDLE = 2'b00,
    REQC_MAREQ = 2'b01,
    REQC_MBOUT = 2'b10,
    REQC_MDEFO = 2'b11
  } reqc_state_e;

  localparam logic [5:0] ATOP_NONE = 6'b000000;

endpackage

// File: rtl/sfifo_sr.sv
// Parametrised synchronous FIFO with synchronous active-high reset.
// Writes while full and reads while empty are ignored.
module sfifo_sr #(
  parameter int WIDTH  = 8,
  parameter int QAW    = 2,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [QAW:0]     count
);

  logic [WIDTH-1:0] mem_r [QDEPTH];
  logic [QAW-1:0]   wr_ptr_r;
  logic [QAW-1:0]   rd_ptr_r;
  logic [QAW:0]     count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == (QAW+1)'(QDEPTH));
  assign empty  = (count_r == {(QAW+1){1'b0}});
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = wen & ~full;
  assign pop_s  = ren & ~empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {QAW{1'b0}};
      rd_ptr_r <= {QAW{1'b0}};
      count_r  <= {(QAW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/req_chan_mngr2.sv
// Request-channel master: queues requests, arbitrates, issues address bursts
// under an outstanding-credit limit. Optional overflow flag: REQC_OVF_CHK_EN.
module req_chan_mngr2
  import req_chan_pkg::*;
#(
  parameter int                MIDW      = 2,
  parameter logic [MIDW-1:0]   REQC_M_ID = 2'b00,
  parameter int                TIDW      = 2,
  parameter int                AW        = 32,
  parameter int                DW        = 128,
  parameter int                QDEPTH    = 4,
  parameter int                QAW       = 2,
  parameter int                MAX_OUTST = 4,
  parameter int                BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_rq,
  input  logic                 gnt_rq,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [MIDW+TIDW-1:0] a_id,
  output logic [AW-1:0]        a_addr,
  output logic [5:0]           a_atop,
  input  logic                 start_rq,
  input  logic [AW-1:0]        in_addr,
  input  logic [DW/8-1:0]      in_mask,
  input  logic [DW-1:0]        in_data,
  output logic                 in_full,
  output logic                 next_rq,
  output logic [MIDW+TIDW-1:0] next_id,
  output logic [DW/8-1:0]      next_mask,
  output logic [DW-1:0]        next_data,
  input  logic                 ren_id_data,
  input  logic                 cmpl_vld,
  output logic                 err_ovf
);

  localparam int MW  = DW / 8;
  localparam int AQW = TIDW + AW;
  localparam int DQW = TIDW + MW + DW;
  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [TIDW:0] OUTST_LIM = (TIDW+1)'(MAX_OUTST);

  reqc_state_e    state_r, state_nxt_s;
  logic [TIDW-1:0] tid_r;
  logic [TIDW:0]  outst_r, outst_nxt_s;
  logic [BCW-1:0] bcnt_r;
  logic [AQW-1:0] a_rdata_s;
  logic [DQW-1:0] d_rdata_s;
  logic           a_full_s, a_empty_s, d_full_s, d_empty_s;
  logic [QAW:0]   a_cnt_s, d_cnt_s;
  logic           enq_s, next_rq_s, cmpl_dec_s, credit_ok_s, stay_s;
  logic           unused_s;

  assign in_full     = a_full_s | d_full_s;
  assign enq_s       = start_rq & ~in_full;
  assign next_rq_s   = a_valid & a_ready;
  assign cmpl_dec_s  = cmpl_vld & (outst_r != {(TIDW+1){1'b0}});
  assign credit_ok_s = (outst_r < OUTST_LIM);
  assign stay_s      = (a_cnt_s >= (QAW+1)'(2))
                     && ((32'(bcnt_r) + 32'd1) < 32'(BURST_MAX))
                     && (outst_nxt_s < OUTST_LIM);
  assign unused_s    = ^{d_empty_s, d_cnt_s};

  sfifo_sr #(.WIDTH(AQW), .QAW(QAW), .QDEPTH(QDEPTH)) u_addr_q (
    .clk(clk), .rst(rst), .wen(enq_s), .wdata({tid_r, in_addr}),
    .ren(next_rq_s), .rdata(a_rdata_s), .full(a_full_s), .empty(a_empty_s),
    .count(a_cnt_s)
  );

  sfifo_sr #(.WIDTH(DQW), .QAW(QAW), .QDEPTH(QDEPTH)) u_data_q (
    .clk(clk), .rst(rst), .wen(enq_s), .wdata({tid_r, in_mask, in_data}),
    .ren(ren_id_data), .rdata(d_rdata_s), .full(d_full_s), .empty(d_empty_s),
    .count(d_cnt_s)
  );

  assign req_rq    = (state_r == REQC_MAREQ);
  assign a_valid   = (state_r == REQC_MBOUT);
  assign a_addr    = a_rdata_s[AW-1:0];
  assign a_id      = {REQC_M_ID, a_rdata_s[AQW-1 -: TIDW]};
  assign a_atop    = ATOP_NONE;
  assign next_rq   = next_rq_s;
  assign next_id   = {REQC_M_ID, d_rdata_s[DQW-1 -: TIDW]};
  assign next_mask = d_rdata_s[DW +: MW];
  assign next_data = d_rdata_s[DW-1:0];

  // Outstanding count: a simultaneous issue and completion cancel out.
  always_comb begin
    outst_nxt_s = outst_r;
    case ({next_rq_s, cmpl_dec_s})
      2'b10:   outst_nxt_s = outst_r + 1'b1;
      2'b01:   outst_nxt_s = outst_r - 1'b1;
      default: outst_nxt_s = outst_r;
    endcase
  end

  // Next-state logic; DEFO only reachable through an illegal encoding.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      REQC_MIDLE: begin
        if (!a_empty_s && credit_ok_s) state_nxt_s = REQC_MAREQ;
        else                           state_nxt_s = REQC_MIDLE;
      end
      REQC_MAREQ: begin
        if (gnt_rq) state_nxt_s = REQC_MBOUT;
        else        state_nxt_s = REQC_MAREQ;
      end
      REQC_MBOUT: begin
        if (a_ready && stay_s) state_nxt_s = REQC_MBOUT;
        else if (a_ready)      state_nxt_s = REQC_MIDLE;
        else                   state_nxt_s = REQC_MBOUT;
      end
      REQC_MDEFO: state_nxt_s = REQC_MDEFO;
      default:    state_nxt_s = REQC_MDEFO;
    endcase
  end

  // State, transaction ID, credit and burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= REQC_MIDLE;
      tid_r   <= {TIDW{1'b0}};
      outst_r <= {(TIDW+1){1'b0}};
      bcnt_r  <= {BCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      outst_r <= outst_nxt_s;
      if (enq_s) tid_r <= tid_r + 1'b1;
      if (state_r == REQC_MAREQ && gnt_rq) bcnt_r <= {BCW{1'b0}};
      else if (next_rq_s)                  bcnt_r <= bcnt_r + 1'b1;
    end
  end

`ifdef REQC_OVF_CHK_EN
  logic err_ovf_r;
  assign err_ovf = err_ovf_r;

  // Sticky record of a request dropped because a queue was full.
  always_ff @(posedge clk) begin
    if (rst)                      err_ovf_r <= 1'b0;
    else if (start_rq && in_full) err_ovf_r <= 1'b1;
  end
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_req_chan_mngr2.sv
// Scoreboard bench for req_chan_mngr2: address handshakes and data-queue
// heads are compared against expectations queued when requests are driven.
module tb_req_chan_mngr2;

`ifdef REQC_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct packed { logic [3:0] id; logic [31:0] addr; } a_exp_t;
  typedef struct packed { logic [3:0] id; logic [15:0] mask; logic [127:0] data; } d_exp_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic         req_rq, gnt_rq = 1'b0, a_valid, a_ready = 1'b0;
  logic [3:0]   a_id, next_id;
  logic [31:0]  a_addr, in_addr = 32'd0;
  logic [5:0]   a_atop;
  logic         start_rq = 1'b0, in_full, next_rq, ren_id_data = 1'b0;
  logic [15:0]  in_mask = 16'd0, next_mask;
  logic [127:0] in_data = 128'd0, next_data;
  logic         cmpl_vld = 1'b0, err_ovf;

  a_exp_t exp_a[$];
  d_exp_t exp_d[$];
  a_exp_t mon_e;
  logic [1:0] exp_tid = 2'd0;
  int n_pass = 0, n_total = 0;

  req_chan_mngr2 dut (
    .clk(clk), .rst(rst), .req_rq(req_rq), .gnt_rq(gnt_rq),
    .a_valid(a_valid), .a_ready(a_ready), .a_id(a_id), .a_addr(a_addr),
    .a_atop(a_atop), .start_rq(start_rq), .in_addr(in_addr),
    .in_mask(in_mask), .in_data(in_data), .in_full(in_full),
    .next_rq(next_rq), .next_id(next_id), .next_mask(next_mask),
    .next_data(next_data), .ren_id_data(ren_id_data), .cmpl_vld(cmpl_vld),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [31:0] addr, input logic [15:0] mask, input logic [127:0] data);
    start_rq = 1'b1; in_addr = addr; in_mask = mask; in_data = data;
    if (!in_full) begin
      exp_a.push_back({{2'b00, exp_tid}, addr});
      exp_d.push_back({{2'b00, exp_tid}, mask, data});
      exp_tid = exp_tid + 2'd1;
    end
    tick();
    start_rq = 1'b0;
  endtask

  task automatic drain_one();
    d_exp_t e;
    if (exp_d.size() == 0) begin
      check_eq("d_empty_model", 160'd1, 160'd0);
    end else begin
      e = exp_d.pop_front();
      check_eq("next_id", next_id, e.id);
      check_eq("next_mask", next_mask, e.mask);
      check_eq("next_data", next_data, e.data);
    end
    ren_id_data = 1'b1;
    tick();
    ren_id_data = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_a.delete(); exp_d.delete(); exp_tid = 2'd0;
    check_eq("rst_req_rq", req_rq, 1'b0);
    check_eq("rst_a_valid", a_valid, 1'b0);
    check_eq("rst_in_full", in_full, 1'b0);
    check_eq("rst_err_ovf", err_ovf, 1'b0);
  endtask

  // Address-side scoreboard: every handshake must match the oldest request.
  always @(negedge clk) begin
    if (next_rq) begin
      if (exp_a.size() == 0) begin
        check_eq("a_unexpected", 160'd1, 160'd0);
      end else begin
        mon_e = exp_a.pop_front();
        check_eq("a_id", a_id, mon_e.id);
        check_eq("a_addr", a_addr, mon_e.addr);
        check_eq("a_atop", a_atop, 6'd0);
      end
    end
  end

  initial begin
    int beats, first, last;
    logic seen;
    tick(); tick();
    reset_dut();
    check_eq("rst_next_rq", next_rq, 1'b0);

    // Single request, grant and ready tied high.
    gnt_rq = 1'b1; a_ready = 1'b1;
    enqueue(32'h1000, 16'hFFFF, 128'h0123_4567_89AB_CDEF);
    check_eq("single_req_p0", req_rq, 1'b0);
    tick();
    check_eq("single_req_p1", req_rq, 1'b1);
    tick();
    check_eq("single_valid_p2", a_valid, 1'b1);
    check_eq("single_next_rq", next_rq, 1'b1);
    check_eq("single_id", a_id, 4'b0000);
    tick();
    check_eq("single_idle_valid", a_valid, 1'b0);
    check_eq("single_idle_req", req_rq, 1'b0);
    drain_one();

    // Burst of four under one grant, then credit stall.
    reset_dut();
    gnt_rq = 1'b0; a_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      enqueue(32'h2000 + 32'(i * 16), 16'h00FF << i, {4{32'hA5A5_0000 + 32'(i)}});
    check_eq("burst_in_full", in_full, 1'b1);
    check_eq("burst_req_wait", req_rq, 1'b1);
    gnt_rq = 1'b1;
    beats = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (next_rq) begin
        beats++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check_eq("burst_beats", beats, 4);
    check_eq("burst_span", last - first, 3);
    check_eq("burst_end_valid", a_valid, 1'b0);
    for (int i = 0; i < 4; i++) drain_one();
    enqueue(32'h5000, 16'h1234, 128'h5);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req_rq) seen = 1'b1;
    end
    check_eq("credit_stall", seen, 1'b0);
    cmpl_vld = 1'b1;
    tick();
    cmpl_vld = 1'b0;
    check_eq("credit_req_p0", req_rq, 1'b0);
    tick();
    check_eq("credit_req_p1", req_rq, 1'b1);
    tick(); tick();
    drain_one();
    check_eq("burst_a_left", exp_a.size(), 0);

    // Overflow: fifth request dropped, tid wraps to 0.
    reset_dut();
    gnt_rq = 1'b0; a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enqueue(32'h3000 + 32'(i), 16'(i), 128'(i * 3));
      if (i == 2) check_eq("ovf_not_full_3", in_full, 1'b0);
      if (i == 3) check_eq("ovf_full_4", in_full, 1'b1);
    end
    check_eq("ovf_err", err_ovf, OVF_EXP);
    check_eq("ovf_tid_wrap", exp_tid, 2'd0);
    for (int i = 0; i < 4; i++) drain_one();
    gnt_rq = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("ovf_a_left", exp_a.size(), 0);
    enqueue(32'h3100, 16'hBEEF, 128'hCAFE);
    drain_one();
    check_eq("ovf_err_hold", err_ovf, OVF_EXP);

    // Backpressure, then reset with a_valid in flight.
    reset_dut();
    gnt_rq = 1'b1; a_ready = 1'b0;
    enqueue(32'h000A_BCD0, 16'h0F0F, 128'h77);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = a_valid;
    end
    check_eq("bp_valid_rise", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid_hold", a_valid, 1'b1);
      check_eq("bp_addr_hold", a_addr, 32'h000A_BCD0);
    end
    reset_dut();
    tick();
    check_eq("post_rst_valid", a_valid, 1'b0);
    check_eq("post_rst_req", req_rq, 1'b0);
    gnt_rq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enqueue(32'h4000 + 32'(i), 16'h1, 128'h1);
      if (i == 2) check_eq("post_rst_room", in_full, 1'b0);
    end
    check_eq("post_rst_full", in_full, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
